pwm_driver: RTL and testbench
=============================

PWM_DRIVER -- requirements
Module: pwm_driver

Interface
REQ-001 The block SHALL have parameter PERIOD, default 128, meaning PWM period in clk cycles (range 2..255).
REQ-002 The block SHALL have parameter DEAD_PERIODS, default 2, meaning the number of whole PWM periods forced low on a direction reversal (range 1..15).
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, rising-edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port ctrl_in, input, signed 8 bits: control command, Q4.4, sign = direction.
REQ-006 The block SHALL have port ctrl_valid, input, 1 bit: ctrl_in is valid this cycle; it is always accepted and no ready signal exists.
REQ-007 The block SHALL have port enable, input, 1 bit: run/stop.
REQ-008 The block SHALL have port pwm_out, output, 1 bit: registered PWM drive.
REQ-009 The block SHALL have port dir_out, output, 1 bit: registered direction, where 1 = negative command.
REQ-010 The block SHALL have port period_start, output, 1 bit: one-cycle pulse at the first cycle of each period.
REQ-011 The block SHALL have port sat_flag, output, 1 bit: the active duty was clamped.

Function
REQ-012 Magnitude SHALL be computed as |ctrl_in|: -128 maps to 127, so mag ranges 0..127 (treated as a raw 8-bit count; Q4.4 scaling is not applied).
REQ-013 Duty SHALL be computed as min(mag, PERIOD); sat for that command is set when mag > PERIOD or ctrl_in == -128.
REQ-014 Shadow register {sdir, sduty, ssat} SHALL load on every cycle with ctrl_valid=1; when several valid cycles occur in one period, the last one wins.
REQ-015 Period counter cnt SHALL count 0..PERIOD-1 and wrap to 0; "wrap" is the cycle where cnt == PERIOD-1.
REQ-016 Active register {dir_out, duty_act, sat_flag} SHALL update only at wrap, never mid-period.
REQ-017 If ctrl_valid=1 in the same cycle as wrap, the active register SHALL take the incoming value (shadow bypass).
REQ-018 pwm_out SHALL be 1 in exactly the cycles where cnt < duty_act and state == RUN; pwm_out and cnt are registered and aligned, with no extra latency between them.
REQ-019 duty_act = 0 SHALL give constant pwm_out=0; duty_act = PERIOD SHALL give constant pwm_out=1.
REQ-020 The state machine SHALL have three states: IDLE, RUN, DEAD.
REQ-021 In IDLE: cnt held at 0, pwm_out=0, period_start=0, dir_out held, shadow still loads.
REQ-022 IDLE -> RUN SHALL occur on enable=1; the active register loads from shadow/bypass, cnt=0 and period_start=1 in the first RUN cycle.
REQ-023 RUN -> IDLE SHALL occur immediately (next cycle) on enable=0, even mid-period; pwm_out is 0 from that cycle.
REQ-024 RUN -> DEAD SHALL occur at wrap when the incoming dir != dir_out and incoming duty != 0; dir_out and duty_act are left unchanged and pwm_out is held 0.
REQ-025 A zero-duty command SHALL never change dir_out and SHALL never trigger DEAD.
REQ-026 DEAD SHALL last exactly DEAD_PERIODS full periods; cnt keeps counting and period_start keeps pulsing.
REQ-027 DEAD -> RUN SHALL occur at the wrap ending the last dead period; the active register then loads the current shadow/bypass value, with no second DEAD even if the direction changed again.
REQ-028 DEAD -> IDLE SHALL occur on enable=0; the dead-period counter is cleared.
REQ-029 period_start SHALL be asserted in the cycle where cnt == 0 while in RUN or DEAD.

Reset
REQ-030 On rst=1, all state SHALL clear asynchronously: state=IDLE, cnt=0, dead counter=0, shadow=0, duty_act=0, pwm_out=0, dir_out=0, period_start=0, sat_flag=0.
REQ-031 Reset mid-period or mid-DEAD SHALL abort immediately; after release the block stays in IDLE until enable=1.
REQ-032 No output SHALL toggle in the cycle rst deasserts.

Verification
REQ-033 Reset then enable=1, ctrl_in=0x20 valid once -> each period has 32 cycles of pwm_out=1 followed by 96 of 0; dir_out=0; sat_flag=0; period_start every 128 cycles.
REQ-034 In RUN at duty 32, ctrl_in=0x40 valid at cnt=50 -> the current period stays at 32; the next period is 64 high / 64 low.
REQ-035 ctrl_in=0x80 (-128) -> dir_out=1 only after 2 all-low periods; then 127 high / 1 low with sat_flag=1.
REQ-036 With PERIOD=16, ctrl_in=0x30 -> pwm_out constantly 1 with sat_flag=1; ctrl_in=0x00 -> constant 0 and dir_out unchanged.
REQ-037 ctrl_valid at wrap with 0x10 while shadow holds 0x08 -> the next period uses 16.
REQ-038 enable=0 at cnt=70 during DEAD -> pwm_out=0, IDLE, cnt=0 next cycle; rst asserted during RUN -> all outputs 0 immediately.

Source files
------------

// File: rtl/pwm_driver.sv
// PWM driver: signed command to magnitude/direction with period-aligned
// duty updates and dead periods forced on direction reversal.
module pwm_driver #(
    parameter int PERIOD       = 128,
    parameter int DEAD_PERIODS = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic signed [7:0] ctrl_in,
    input  logic              ctrl_valid,
    input  logic              enable,
    output logic              pwm_out,
    output logic              dir_out,
    output logic              period_start,
    output logic              sat_flag
);

    localparam logic [7:0] PLEN  = 8'(PERIOD);
    localparam logic [7:0] LAST  = 8'(PERIOD - 1);
    localparam logic [3:0] DLAST = 4'(DEAD_PERIODS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DEAD
    } state_t;

    state_t     state;
    logic [7:0] cnt;
    logic [7:0] duty_act;
    logic [3:0] dcnt;
    logic       sdir;
    logic       ssat;
    logic [7:0] sduty;

    logic [7:0] raw;
    logic [7:0] mag;
    logic [7:0] c_duty;
    logic       c_dir;
    logic       c_sat;
    logic [7:0] in_duty;
    logic       in_dir;
    logic       in_sat;
    logic       ld_dir;
    logic       wrap;
    logic       reverse;
    logic [7:0] cnt_inc;

    always_comb begin
        raw = ctrl_in;
        if (raw == 8'h80) begin
            mag = 8'd127;
        end else if (raw[7]) begin
            mag = ~raw + 8'd1;
        end else begin
            mag = raw;
        end
        c_dir  = raw[7];
        c_duty = (mag > PLEN) ? PLEN : mag;
        c_sat  = (mag > PLEN) || (raw == 8'h80);
        // A command arriving in the same cycle bypasses the shadow
        in_dir  = ctrl_valid ? c_dir  : sdir;
        in_duty = ctrl_valid ? c_duty : sduty;
        in_sat  = ctrl_valid ? c_sat  : ssat;
        ld_dir  = (in_duty == 8'd0) ? dir_out : in_dir;
        reverse = (in_duty != 8'd0) && (in_dir != dir_out);
        wrap    = (cnt == LAST);
        cnt_inc = cnt + 8'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= 8'd0;
            dcnt         <= 4'd0;
            duty_act     <= 8'd0;
            sdir         <= 1'b0;
            sduty        <= 8'd0;
            ssat         <= 1'b0;
            pwm_out      <= 1'b0;
            dir_out      <= 1'b0;
            period_start <= 1'b0;
            sat_flag     <= 1'b0;
        end else begin
            if (ctrl_valid) begin
                sdir  <= c_dir;
                sduty <= c_duty;
                ssat  <= c_sat;
            end
            pwm_out      <= 1'b0;
            period_start <= 1'b0;
            unique case (state)
                IDLE: begin
                    cnt  <= 8'd0;
                    dcnt <= 4'd0;
                    if (enable) begin
                        state        <= RUN;
                        duty_act     <= in_duty;
                        sat_flag     <= in_sat;
                        dir_out      <= ld_dir;
                        period_start <= 1'b1;
                        pwm_out      <= (in_duty != 8'd0);
                    end
                end
                RUN: begin
                    if (!enable) begin
                        state <= IDLE;
                        cnt   <= 8'd0;
                    end else if (wrap) begin
                        cnt          <= 8'd0;
                        period_start <= 1'b1;
                        if (reverse) begin
                            state <= DEAD;
                            dcnt  <= 4'd0;
                        end else begin
                            duty_act <= in_duty;
                            sat_flag <= in_sat;
                            dir_out  <= ld_dir;
                            pwm_out  <= (in_duty != 8'd0);
                        end
                    end else begin
                        cnt     <= cnt_inc;
                        pwm_out <= (cnt_inc < duty_act);
                    end
                end
                DEAD: begin
                    if (!enable) begin
                        state <= IDLE;
                        cnt   <= 8'd0;
                        dcnt  <= 4'd0;
                    end else if (wrap) begin
                        cnt          <= 8'd0;
                        period_start <= 1'b1;
                        if (dcnt == DLAST) begin
                            // Leave DEAD on whatever is current, even a new reversal
                            state    <= RUN;
                            dcnt     <= 4'd0;
                            duty_act <= in_duty;
                            sat_flag <= in_sat;
                            dir_out  <= ld_dir;
                            pwm_out  <= (in_duty != 8'd0);
                        end else begin
                            dcnt <= dcnt + 4'd1;
                        end
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 8'd0;
                    dcnt  <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_driver.sv
// Bench for pwm_driver: two parameterisations driven together and
// compared every cycle against a period-level reference model.
module tb_pwm_driver;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic signed [7:0] ci  = 8'sd0;
    logic              cv  = 1'b0;
    logic              en  = 1'b0;
    logic [1:0]        pwm;
    logic [1:0]        dir;
    logic [1:0]        ps;
    logic [1:0]        sat;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pwm_driver #(.PERIOD(128), .DEAD_PERIODS(2)) dut0 (
        .clk(clk), .rst(rst), .ctrl_in(ci), .ctrl_valid(cv),
        .enable(en), .pwm_out(pwm[0]), .dir_out(dir[0]),
        .period_start(ps[0]), .sat_flag(sat[0])
    );

    pwm_driver #(.PERIOD(16), .DEAD_PERIODS(3)) dut1 (
        .clk(clk), .rst(rst), .ctrl_in(ci), .ctrl_valid(cv),
        .enable(en), .pwm_out(pwm[1]), .dir_out(dir[1]),
        .period_start(ps[1]), .sat_flag(sat[1])
    );

    // Reference model: mode 0 stopped, 1 driving, 2 dead
    int P[2] = '{128, 16};
    int D[2] = '{2, 3};
    int mode[2];
    int pos[2];
    int dleft[2];
    int adir[2];
    int aduty[2];
    int asat[2];
    int sdir[2];
    int sduty[2];
    int ssat[2];

    function automatic void load(int k);
        aduty[k] = sduty[k];
        asat[k]  = ssat[k];
        if (sduty[k] != 0) adir[k] = sdir[k];
    endfunction

    function automatic void step(int k);
        int c;
        int mag;
        bit endp;
        if (cv) begin
            c = ci;
            mag = (c == -128) ? 127 : ((c < 0) ? -c : c);
            sdir[k]  = (c < 0);
            sduty[k] = (mag < P[k]) ? mag : P[k];
            ssat[k]  = (mag > P[k]) || (c == -128);
        end
        endp = (pos[k] == P[k] - 1);
        if (mode[k] == 0) begin
            if (en) begin
                mode[k] = 1;
                pos[k]  = 0;
                load(k);
            end
        end else if (!en) begin
            mode[k]  = 0;
            pos[k]   = 0;
            dleft[k] = 0;
        end else if (!endp) begin
            pos[k] = pos[k] + 1;
        end else begin
            pos[k] = 0;
            if (mode[k] == 1) begin
                if (sduty[k] != 0 && sdir[k] != adir[k]) begin
                    mode[k]  = 2;
                    dleft[k] = D[k];
                end else begin
                    load(k);
                end
            end else begin
                dleft[k] = dleft[k] - 1;
                if (dleft[k] == 0) begin
                    mode[k] = 1;
                    load(k);
                end
            end
        end
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                mode[k] = 0;  pos[k] = 0;   dleft[k] = 0;
                adir[k] = 0;  aduty[k] = 0; asat[k] = 0;
                sdir[k] = 0;  sduty[k] = 0; ssat[k] = 0;
            end else begin
                step(k);
            end
        end
    end

    task automatic chk(string tag, int obs, int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            if (fails < 30)
                $error("FAIL %s: observed %0d expected %0d at %0t",
                       tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("pwm%0d", k), int'(pwm[k]),
                int'(mode[k] == 1 && pos[k] < aduty[k]));
            chk($sformatf("ps%0d", k), int'(ps[k]),
                int'(mode[k] != 0 && pos[k] == 0));
            chk($sformatf("dir%0d", k), int'(dir[k]), adir[k]);
            chk($sformatf("sat%0d", k), int'(sat[k]), asat[k]);
        end
    endtask

    task automatic send(logic signed [7:0] v);
        ci = v;
        cv = 1'b1;
        tick();
        cv = 1'b0;
    endtask

    task automatic wait_at(int k, int m, int p);
        int n = 0;
        while (!(mode[k] == m && pos[k] == p) && n < 2000) begin
            tick();
            n++;
        end
        if (n >= 2000) chk("wait_timeout", n, 0);
    endtask

    task automatic measure(int k, int exp, string tag);
        int n = 0;
        int hi = 0;
        while (ps[k] !== 1'b1 && n < 600) begin
            tick();
            n++;
        end
        if (n >= 600) chk({tag, "_timeout"}, n, 0);
        for (int i = 0; i < P[k]; i++) begin
            hi += int'(pwm[k]);
            tick();
        end
        chk(tag, hi, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_pwm", int'(pwm), 0);
        chk("rst_dir", int'(dir), 0);
        chk("rst_ps", int'(ps), 0);
        chk("rst_sat", int'(sat), 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        do_reset();
        for (int i = 0; i < 5; i++) tick();

        en = 1'b1;
        send(8'sh20);
        measure(0, 32, "duty32");
        measure(0, 32, "duty32_again");
        chk("dir_pos", int'(dir[0]), 0);

        wait_at(0, 1, 50);
        send(8'sh40);
        measure(0, 64, "duty64_next");

        send(-8'sd128);
        measure(0, 0, "dead1");
        chk("dir_held", int'(dir[0]), 0);
        measure(0, 0, "dead2");
        measure(0, 127, "neg_full");
        chk("dir_neg", int'(dir[0]), 1);
        chk("sat_neg", int'(sat[0]), 1);

        send(8'sh30);
        for (int i = 0; i < 200; i++) tick();
        measure(1, 16, "p16_sat");
        chk("p16_satflag", int'(sat[1]), 1);
        send(8'sh00);
        for (int i = 0; i < 40; i++) tick();
        measure(1, 0, "p16_zero");
        chk("p16_dir_kept", int'(dir[1]), 0);

        en = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) tick();
        chk("idle_after_rst", int'(ps[0]), 0);
        en = 1'b1;
        send(8'sh08);
        measure(0, 8, "duty8");
        wait_at(0, 1, 127);
        send(8'sh10);
        measure(0, 16, "bypass16");

        send(-8'sd32);
        wait_at(0, 2, 70);
        en = 1'b0;
        tick();
        chk("dead_stop_pwm", int'(pwm[0]), 0);
        chk("dead_stop_ps", int'(ps[0]), 0);
        chk("dead_stop_idle", mode[0], 0);
        en = 1'b1;
        send(8'sh20);
        for (int i = 0; i < 50; i++) tick();
        do_reset();

        for (int i = 0; i < 8000; i++) begin
            if (en) begin
                if ($urandom_range(299) == 0) en = 1'b0;
            end else if ($urandom_range(19) == 0) begin
                en = 1'b1;
            end
            cv = ($urandom_range(39) == 0);
            case ($urandom_range(7))
                0: ci = -8'sd128;
                1: ci = 8'sd127;
                2: ci = 8'sd0;
                3: ci = 8'sd16;
                4: ci = -8'sd16;
                default: ci = 8'($urandom);
            endcase
            if ($urandom_range(2999) == 0) begin
                cv = 1'b0;
                do_reset();
            end else begin
                tick();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
